data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 31 +++
 rtl/data_mem_responder_mem_ram_sp.sv | 34 +++
 rtl/data_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared types and constants for the data-memory responder:
//   - state_e      : responder FSM encoding (IDLE / WAIT / DONE)
//   - CNT_W        : width of the wait-state counter
//   - MAX_WAIT     : largest wait-state count the counter can hold
//   - addr_error() : misaligned / out-of-range check for a CPU byte address
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = (1 << CNT_W) - 1;

  // An access is in error when the byte address is not word aligned or when
  // any bit above the RAM's word-address field is set. The high mask keeps
  // bits [31:aw+2]; for very wide RAMs the mask collapses to zero.
  function automatic logic addr_error(input logic [31:0] addr,
                                      input int unsigned aw);
    logic [31:0] hi_mask;
    if (aw + 2 >= 32) hi_mask = '0;
    else              hi_mask = ~((32'd1 << (aw + 2)) - 32'd1);
    return (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'd0);
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_ram_sp.sv
// -----------------------------------------------------------------------------
// mem_ram_sp
//   Single-port synchronous RAM, 2^ADDR_WIDTH words of DATA_WIDTH bits.
//   No reset: contents and dout power up undefined.
//   Ports:
//     clk  : rising-edge clock
//     en   : port enable; nothing happens when low
//     we   : write enable (write when en & we, read when en & ~we)
//     addr : word address
//     din  : write data
//     dout : registered read data; holds its value on writes and idle cycles
// -----------------------------------------------------------------------------
module mem_ram_sp #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the pipelined CPU's data-memory port. Models a
//   word-addressed single-port RAM with WAIT_STATES extra busy cycles/access.
//
//   Parameters:
//     ADDR_WIDTH  : word-address width, RAM depth 2^ADDR_WIDTH x 32 bits
//     WAIT_STATES : extra busy cycles per access, 0..15
//   Ports:
//     clk, rst_n : rising-edge clock, asynchronous active-low reset
//     mem_ren    : read request from the MEM stage
//     mem_wen    : write request (wins when both requests are high)
//     mem_addr   : byte address
//     mem_dout   : write data from the CPU
//     mem_din    : read data to the CPU
//     mem_stall  : access in progress, CPU must hold its request stable
//     mem_err    : one-cycle pulse in DONE when the access was in error
//     busy       : FSM not IDLE
//
//   Handshake: the request (mem_ren|mem_wen) acts as "valid" and ~mem_stall as
//   "ready". A request is accepted in the IDLE cycle it is first seen and
//   mem_stall stays high until the DONE cycle, where it drops; the transfer
//   completes in that cycle. Dropping the request before DONE aborts the
//   access with no write and no error. Address/data are latched at accept, so
//   changes while stalled are ignored.
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        busy
);

  if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT) begin : g_bad_wait_states
    $error("data_mem_responder: WAIT_STATES=%0d outside 0..%0d",
           WAIT_STATES, MAX_WAIT);
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
    $error("data_mem_responder: ADDR_WIDTH=%0d outside 1..30", ADDR_WIDTH);
  end

  localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);
  localparam bit               NO_WAIT = (WAIT_STATES == 0);

  // Registered state
  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   lat_addr_q;
  logic [31:0]             lat_data_q;
  logic                    lat_write_q;
  logic                    lat_err_q;
  logic                    err_q;
  logic                    din_valid_q;

  // Request decode
  logic                    req;
  logic                    req_err;
  logic [ADDR_WIDTH-1:0]   req_word;

  assign req      = mem_ren | mem_wen;
  assign req_err  = addr_error(mem_addr, ADDR_WIDTH);
  assign req_word = mem_addr[ADDR_WIDTH+1:2];

  // Edge into DONE: either straight from IDLE (no wait states) or from the
  // last WAIT cycle. Kind/error come from the live request in the first case
  // and from the latched copy in the second.
  logic enter_from_idle;
  logic enter_from_wait;
  logic enter_done;
  logic done_write;
  logic done_err;

  assign enter_from_idle = NO_WAIT && (state_q == ST_IDLE) && req;
  assign enter_from_wait = (state_q == ST_WAIT) && req && (cnt_q == CNT_W'(1));
  assign enter_done      = enter_from_idle | enter_from_wait;
  assign done_write      = enter_from_idle ? mem_wen : lat_write_q;
  assign done_err        = enter_from_idle ? req_err : lat_err_q;

  // RAM port: the read is issued on the edge entering DONE so its registered
  // output is valid during DONE; the write commits on the edge leaving DONE.
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_dout;

  assign rd_fire  = enter_done && !done_write && !done_err;
  assign wr_fire  = (state_q == ST_DONE) && lat_write_q && !lat_err_q;
  assign ram_en   = rd_fire | wr_fire;
  assign ram_we   = wr_fire;
  assign ram_addr = (state_q == ST_IDLE) ? req_word : lat_addr_q;

  mem_ram_sp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (32)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (lat_data_q),
    .dout (ram_dout)
  );

  // Responder FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lat_addr_q  <= '0;
      lat_data_q  <= '0;
      lat_write_q <= 1'b0;
      lat_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            lat_addr_q  <= req_word;
            lat_data_q  <= mem_dout;
            lat_write_q <= mem_wen;
            lat_err_q   <= req_err;
            cnt_q       <= WS_INIT;
            state_q     <= NO_WAIT ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!req) begin
            // Abort: the latched write is simply never committed.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Completion outputs. mem_din is the RAM output register qualified by
  // din_valid_q: an error (or reset) forces it to zero, a clean read exposes
  // the freshly read word, and a write leaves the previous value in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      din_valid_q <= 1'b0;
    end else begin
      err_q <= enter_done & done_err;
      if (enter_done) begin
        if (done_err)         din_valid_q <= 1'b0;
        else if (!done_write) din_valid_q <= 1'b1;
      end
    end
  end

  assign mem_din   = din_valid_q ? ram_dout : 32'd0;
  assign mem_err   = err_q;
  assign busy      = (state_q != ST_IDLE);
  // Held low during reset so the stall drops with rst_n, not at a clock edge.
  assign mem_stall = rst_n & req & (state_q != ST_DONE);

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Two responders share clock and reset: index 0 has WAIT_STATES=2, index 1
//   has WAIT_STATES=0. A table of accesses runs on the first, then
//   hand-written sequences cover abort, asynchronous reset and zero-wait use.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ren;
  logic [1:0]  wen;
  logic [31:0] addr [2];
  logic [31:0] dout [2];
  logic [31:0] din  [2];
  logic [1:0]  stall;
  logic [1:0]  err;
  logic [1:0]  busy;

  int n_checks;
  int n_fail;

  // ---------------------------------------------------------------- clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_ren   (ren[0]),
    .mem_wen   (wen[0]),
    .mem_addr  (addr[0]),
    .mem_dout  (dout[0]),
    .mem_din   (din[0]),
    .mem_stall (stall[0]),
    .mem_err   (err[0]),
    .busy      (busy[0])
  );

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_ren   (ren[1]),
    .mem_wen   (wen[1]),
    .mem_addr  (addr[1]),
    .mem_dout  (dout[1]),
    .mem_din   (din[1]),
    .mem_stall (stall[1]),
    .mem_err   (err[1]),
    .busy      (busy[1])
  );

  // ---------------------------------------------------------------- scoreboard
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp_v;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Starts just after a rising edge with the FSM idle. Counts stall cycles
  // (bounded), samples the DONE cycle, drops the request and samples the
  // following cycle.
  task automatic access(input int s, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        output int ncyc, output logic e_done,
                        output logic [31:0] din_done, output logic e_after,
                        output logic busy_after);
    ren[s]  = r;
    wen[s]  = w;
    addr[s] = a;
    dout[s] = d;
    #1;
    ncyc = 0;
    while (stall[s] && ncyc < 40) begin
      ncyc++;
      @(posedge clk);
      #1;
    end
    e_done   = err[s];
    din_done = din[s];
    ren[s]   = 1'b0;
    wen[s]   = 1'b0;
    @(posedge clk);
    #1;
    e_after    = err[s];
    busy_after = busy[s];
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          exp_cyc;
    logic        exp_err;
    logic        chk_din;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vt [15];

  int          ncyc;
  logic        e_done;
  logic        e_after;
  logic        b_after;
  logic [31:0] din_done;

  task automatic run_access(input int s, input string name, input logic r,
                            input logic w, input logic [31:0] a,
                            input logic [31:0] d, input int exp_cyc,
                            input logic exp_err, input logic chk_din,
                            input logic [31:0] exp_din);
    access(s, r, w, a, d, ncyc, e_done, din_done, e_after, b_after);
    exp_q.push_back(32'(exp_cyc));
    check({name, " stall_cycles"}, 32'(ncyc));
    exp_q.push_back({31'd0, exp_err});
    check({name, " err_in_done"}, {31'd0, e_done});
    exp_q.push_back(32'd0);
    check({name, " err_after_done"}, {31'd0, e_after});
    exp_q.push_back(32'd0);
    check({name, " busy_after_done"}, {31'd0, b_after});
    if (chk_din) begin
      exp_q.push_back(exp_din);
      check({name, " din"}, din_done);
    end
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    ren      = '0;
    wen      = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0;
      dout[i] = '0;
    end

    //            r     w     addr          data          cyc err   chk   din
    vt[0]  = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 3, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         3, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[2]  = '{1'b0, 1'b1, 32'h0000_0042, 32'hFFFF_FFFF, 3, 1'b1, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         3, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[4]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         3, 1'b1, 1'b1, 32'h0};
    vt[5]  = '{1'b0, 1'b1, 32'h0000_0048, 32'h1111_2222, 3, 1'b0, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 1'b1, 32'h0000_004C, 32'h4C4C_4C4C, 3, 1'b0, 1'b0, 32'h0};
    vt[7]  = '{1'b1, 1'b1, 32'h0000_0050, 32'hCAFE_F00D, 3, 1'b0, 1'b0, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 32'h0000_0050, 32'h0,         3, 1'b0, 1'b1, 32'hCAFE_F00D};
    vt[9]  = '{1'b0, 1'b1, 32'hFFFF_0040, 32'h0000_0BAD, 3, 1'b1, 1'b0, 32'h0};
    vt[10] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         3, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[11] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 3, 1'b0, 1'b0, 32'h0};
    vt[12] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         3, 1'b0, 1'b1, 32'h0BAD_CAFE};
    vt[13] = '{1'b1, 1'b0, 32'h0000_1003, 32'h0,         3, 1'b1, 1'b1, 32'h0};
    vt[14] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,         3, 1'b0, 1'b1, 32'h1111_2222};

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset values on both instances
    for (int s = 0; s < 2; s++) begin
      exp_q.push_back(32'd0); check($sformatf("reset%0d busy", s),  {31'd0, busy[s]});
      exp_q.push_back(32'd0); check($sformatf("reset%0d stall", s), {31'd0, stall[s]});
      exp_q.push_back(32'd0); check($sformatf("reset%0d err", s),   {31'd0, err[s]});
      exp_q.push_back(32'd0); check($sformatf("reset%0d din", s),   din[s]);
    end

    // Table of accesses, WAIT_STATES=2
    for (int i = 0; i < 15; i++) begin
      run_access(0, $sformatf("vec%0d", i), vt[i].r, vt[i].w, vt[i].a, vt[i].d,
                 vt[i].exp_cyc, vt[i].exp_err, vt[i].chk_din, vt[i].exp_din);
    end

    // Abort: write 0x48 then drop the request while waiting
    wen[0]  = 1'b1;
    addr[0] = 32'h0000_0048;
    dout[0] = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    exp_q.push_back(32'd1); check("abort busy_in_wait", {31'd0, busy[0]});
    wen[0] = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(32'd0); check("abort busy_after", {31'd0, busy[0]});
    exp_q.push_back(32'd0); check("abort err", {31'd0, err[0]});
    run_access(0, "abort_readback", 1'b1, 1'b0, 32'h0000_0048, 32'h0, 3, 1'b0,
               1'b1, 32'h1111_2222);

    // Async reset during WAIT of a write to 0x4C (mem_din is non-zero here)
    run_access(0, "pre_reset_read", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, 1'b0,
               1'b1, 32'hDEAD_BEEF);
    wen[0]  = 1'b1;
    addr[0] = 32'h0000_004C;
    dout[0] = 32'h9999_9999;
    @(posedge clk);
    #1;
    exp_q.push_back(32'd1); check("rst busy_in_wait", {31'd0, busy[0]});
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(32'd0); check("rst stall", {31'd0, stall[0]});
    exp_q.push_back(32'd0); check("rst busy",  {31'd0, busy[0]});
    exp_q.push_back(32'd0); check("rst din",   din[0]);
    exp_q.push_back(32'd0); check("rst err",   {31'd0, err[0]});
    wen[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_access(0, "rst_readback", 1'b1, 1'b0, 32'h0000_004C, 32'h0, 3, 1'b0,
               1'b1, 32'h4C4C_4C4C);

    // Zero wait states
    run_access(1, "ws0_write", 1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, 1, 1'b0,
               1'b0, 32'h0);
    run_access(1, "ws0_read", 1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 1'b0,
               1'b1, 32'h1234_5678);
    run_access(1, "ws0_misaligned", 1'b1, 1'b0, 32'h0000_0046, 32'h0, 1, 1'b1,
               1'b1, 32'h0);
    run_access(1, "ws0_reread", 1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 1'b0,
               1'b1, 32'h1234_5678);

    // ---------------------------------------------------------------- report
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
